// File: rtl/addsub_pkg.sv
// Shared definitions for the add/sub/accumulate unit.
// The controller that drives op imports the same encodings.
package addsub_pkg;

   // Operation select as it appears on the op port
   typedef enum logic [1:0] {
      OP_SUB  = 2'd0,
      OP_ADD  = 2'd1,
      OP_HOLD = 2'd2,
      OP_ACC  = 2'd3
   } op_e;

endpackage

// File: rtl/addsub_core.sv
// Combinational SIZE-bit add/subtract with carry (borrow on subtract)
// and signed two's-complement overflow of the unsaturated result.
module addsub_core #(
   parameter int SIZE = 4
) (
   input  logic [SIZE-1:0] a,
   input  logic [SIZE-1:0] b,
   input  logic            sub,
   output logic [SIZE-1:0] sum,
   output logic            carry,
   output logic            ovf
);

   logic [SIZE:0] raw;

   // The extra top bit of the widened result doubles as borrow on subtract
   always_comb begin
      if (sub) begin
         raw = {1'b0, a} - {1'b0, b};
         ovf = (a[SIZE-1] != b[SIZE-1]) && (raw[SIZE-1] != a[SIZE-1]);
      end else begin
         raw = {1'b0, a} + {1'b0, b};
         ovf = (a[SIZE-1] == b[SIZE-1]) && (raw[SIZE-1] != a[SIZE-1]);
      end
      sum   = raw[SIZE-1:0];
      carry = raw[SIZE];
   end

endmodule

// File: rtl/addsub_pipe.sv
// Registered add/sub/accumulate unit with valid/ready handshake, one output
// register stage, optional unsigned saturation.
module addsub_pipe
   import addsub_pkg::*;
#(
   parameter int SIZE = 4,
   parameter bit SAT  = 1'b0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [SIZE-1:0] left,
   input  logic [SIZE-1:0] right,
   input  logic [1:0]      op,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [SIZE-1:0] res,
   output logic            carry,
   output logic            ovf
);

   op_e             opCode;
   logic            accept;
   logic            isSub;
   logic [SIZE-1:0] coreA;
   logic [SIZE-1:0] coreSum;
   logic            coreCarry;
   logic            coreOvf;
   logic [SIZE-1:0] nextRes;

   assign opCode   = op_e'(op);
   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;
   assign isSub    = (opCode == OP_SUB);

   // Accumulate reads the output register directly, so back-to-back beats
   // always see the previous accepted result
   assign coreA = (opCode == OP_ACC) ? res : left;

   addsub_core #(.SIZE(SIZE)) u_core (
      .a     (coreA),
      .b     (right),
      .sub   (isSub),
      .sum   (coreSum),
      .carry (coreCarry),
      .ovf   (coreOvf)
   );

   // Saturation clamps only the result; the flags still describe the raw op
   always_comb begin
      nextRes = coreSum;
      if (SAT && coreCarry) begin
         nextRes = isSub ? '0 : '1;
      end
   end

   // Output register: a hold beat re-emits the stored result untouched
   always_ff @(posedge clk) begin
      if (rst) begin
         res       <= '0;
         carry     <= 1'b0;
         ovf       <= 1'b0;
         out_valid <= 1'b0;
      end else if (accept) begin
         out_valid <= 1'b1;
         if (opCode != OP_HOLD) begin
            res   <= nextRes;
            carry <= coreCarry;
            ovf   <= coreOvf;
         end
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_addsub_pipe.sv
// Scoreboard bench for addsub_pipe: a wrap-around and a saturating instance
// share one stimulus stream and are checked against an integer model.
module tb_addsub_pipe;

   typedef struct {
      int res;
      int carry;
      int ovf;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       inValid = 1'b0;
   logic [3:0] left = '0;
   logic [3:0] right = '0;
   logic [1:0] op = '0;
   logic       outReady = 1'b1;

   logic       inReady0, outValid0, carry0, ovf0;
   logic       inReady1, outValid1, carry1, ovf1;
   logic [3:0] res0, res1;

   int   checks = 0;
   int   failures = 0;
   exp_t q0[$];
   exp_t q1[$];
   exp_t mState0, mState1;
   bit   mValid = 1'b0;

   always #5 clk = ~clk;

   addsub_pipe #(.SIZE(4), .SAT(1'b0)) u_wrap (
      .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady0),
      .left(left), .right(right), .op(op), .out_valid(outValid0),
      .out_ready(outReady), .res(res0), .carry(carry0), .ovf(ovf0)
   );

   addsub_pipe #(.SIZE(4), .SAT(1'b1)) u_sat (
      .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady1),
      .left(left), .right(right), .op(op), .out_valid(outValid1),
      .out_ready(outReady), .res(res1), .carry(carry1), .ovf(ovf1)
   );

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Reference arithmetic in plain integers, independent of bit slicing
   function automatic exp_t modelStep(input int sat, input exp_t prev, input int o,
                                      input int l, input int r);
      exp_t e;
      int a, s, sa, sb, ss;
      if (o == 2) return prev;
      a  = (o == 3) ? prev.res : l;
      s  = (o == 0) ? a - r : a + r;
      sa = (a > 7) ? a - 16 : a;
      sb = (r > 7) ? r - 16 : r;
      ss = (o == 0) ? sa - sb : sa + sb;
      e.carry = (s < 0 || s > 15) ? 1 : 0;
      e.ovf   = (ss > 7 || ss < -8) ? 1 : 0;
      e.res   = s & 15;
      if (sat != 0 && e.carry == 1) e.res = (o == 0) ? 0 : 15;
      return e;
   endfunction

   // One clock cycle: drive at the falling edge, compare, update model
   task automatic applyStimulus(input bit v, input int o, input int l, input int r,
                                input bit ordy, input bit rs);
      bit expReady;
      inValid  = v;
      op       = o[1:0];
      left     = l[3:0];
      right    = r[3:0];
      outReady = ordy;
      rst      = rs;
      #1;
      if (rs) begin
         q0.delete();
         q1.delete();
         mState0 = '{0, 0, 0};
         mState1 = '{0, 0, 0};
         mValid  = 1'b0;
      end else begin
         expReady = !mValid || ordy;
         checkOutput("out_valid0", outValid0, mValid);
         checkOutput("out_valid1", outValid1, mValid);
         checkOutput("in_ready0", inReady0, expReady);
         checkOutput("in_ready1", inReady1, expReady);
         if (mValid) begin
            checkOutput("sb_depth", q0.size(), 1);
            if (q0.size() > 0 && q1.size() > 0) begin
               checkOutput("res0", res0, q0[0].res);
               checkOutput("carry0", carry0, q0[0].carry);
               checkOutput("ovf0", ovf0, q0[0].ovf);
               checkOutput("res1", res1, q1[0].res);
               checkOutput("carry1", carry1, q1[0].carry);
               checkOutput("ovf1", ovf1, q1[0].ovf);
               if (ordy) begin
                  void'(q0.pop_front());
                  void'(q1.pop_front());
               end
            end
         end
         if (v && expReady) begin
            mState0 = modelStep(0, mState0, o, l, r);
            mState1 = modelStep(1, mState1, o, l, r);
            q0.push_back(mState0);
            q1.push_back(mState1);
            mValid = 1'b1;
         end else if (mValid && ordy) begin
            mValid = 1'b0;
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      @(negedge clk);
      applyStimulus(0, 0, 0, 0, 1, 1);
      applyStimulus(0, 0, 0, 0, 1, 1);
      #1;
      checkOutput("rst_res", res0, 0);
      checkOutput("rst_valid", outValid0, 0);
      checkOutput("rst_ready", inReady0, 1);

      // Directed arithmetic cases
      applyStimulus(1, 1, 7, 9, 1, 0);
      checkOutput("add79_res", res0, 0);
      checkOutput("add79_carry", carry0, 1);
      checkOutput("add79_ovf", ovf0, 0);
      applyStimulus(1, 1, 5, 4, 1, 0);
      checkOutput("add54_res", res0, 9);
      checkOutput("add54_ovf", ovf0, 1);
      applyStimulus(1, 0, 3, 5, 1, 0);
      checkOutput("sub35_res_wrap", res0, 14);
      checkOutput("sub35_borrow", carry0, 1);
      checkOutput("sub35_ovf", ovf0, 0);
      checkOutput("sub35_res_sat", res1, 0);

      // Accumulate chain from a cleared register
      applyStimulus(1, 1, 0, 0, 1, 0);
      applyStimulus(1, 3, 0, 3, 1, 0);
      checkOutput("acc1", res0, 3);
      applyStimulus(1, 3, 0, 3, 1, 0);
      checkOutput("acc2", res0, 6);
      applyStimulus(1, 3, 0, 3, 1, 0);
      checkOutput("acc3", res0, 9);
      applyStimulus(1, 3, 0, 8, 1, 0);
      checkOutput("acc_sat_res", res1, 15);
      checkOutput("acc_sat_carry", carry1, 1);

      // Hold re-emits the previous result
      applyStimulus(1, 1, 2, 3, 1, 0);
      applyStimulus(1, 2, 9, 9, 1, 0);
      checkOutput("hold_res", res0, 5);
      checkOutput("hold_valid", outValid0, 1);
      checkOutput("hold_carry", carry0, 0);

      // Backpressure with the upstream beat held
      applyStimulus(1, 1, 1, 1, 1, 0);
      for (int i = 0; i < 3; i++) applyStimulus(1, 1, 4, 4, 0, 0);
      applyStimulus(1, 1, 4, 4, 1, 0);
      applyStimulus(1, 1, 6, 1, 1, 0);
      applyStimulus(1, 0, 2, 7, 1, 0);

      // Reset while stalled drops the pending result
      applyStimulus(1, 1, 2, 2, 1, 0);
      applyStimulus(1, 1, 3, 3, 0, 0);
      applyStimulus(1, 1, 3, 3, 0, 1);
      #1;
      checkOutput("rst_stall_valid", outValid0, 0);
      checkOutput("rst_stall_res", res0, 0);
      checkOutput("rst_stall_carry", carry0, 0);
      checkOutput("rst_stall_ovf", ovf0, 0);
      checkOutput("rst_stall_ready", inReady0, 1);

      // Random traffic
      for (int i = 0; i < 200; i++) begin
         applyStimulus($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 15),
                       $urandom_range(0, 15), ($urandom_range(0, 3) != 0), 0);
      end

      // Drain and confirm nothing is left pending
      for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 1, 0);
      checkOutput("drain_q", q0.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
